// File: rtl/coin_if.sv
// Coin-acceptor signal bundle: raw sensor lines and accept_en in, clean coin pulses
// and status out. The slave modport is the acceptor side.
interface coin_if #(
    parameter int TOTAL_W = 8
);
    logic               coin_nickel_raw;
    logic               coin_dime_raw;
    logic               accept_en;
    logic               nickel_in;
    logic               dime_in;
    logic               coin_reject;
    logic               busy;
    logic [TOTAL_W-1:0] cents_total;

    modport master (
        output coin_nickel_raw, coin_dime_raw, accept_en,
        input  nickel_in, dime_in, coin_reject, busy, cents_total
    );

    modport slave (
        input  coin_nickel_raw, coin_dime_raw, accept_en,
        output nickel_in, dime_in, coin_reject, busy, cents_total
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces two coin sensors, turns rising
// edges into single-cycle credit or reject pulses, and keeps a saturating cents total.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int TOTAL_W         = 8
) (
    input logic   clock,
    input logic   reset,
    coin_if.slave bus
);
    localparam int CNT_W  = 4;
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam int SUM_W  = TOTAL_W + 1;
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PULSE   = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    // Channel index 0 is the nickel sensor, index 1 the dime sensor.
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_armed;
    logic [1:0]       r_event;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       r_warm;
    logic             w_warm;

    assign w_raw  = {bus.coin_dime_raw, bus.coin_nickel_raw};
    assign w_warm = (r_warm == 2'd2);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values and process order cannot change the result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_warm  <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            if (!w_warm) r_warm <= r_warm + 2'd1;
        end
    end

    // A channel only produces events once its synchronized line has been seen low,
    // so a sensor held high across reset release settles silently.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_deb   <= '0;
            r_armed <= '0;
            r_event <= '0;
            for (int c = 0; c < 2; c++) r_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                r_event[c] <= 1'b0;
                if (w_warm && !r_sync2[c]) r_armed[c] <= 1'b1;
                if (r_sync2[c] != r_deb[c]) begin
                    if (r_cnt[c] == DB_LAST) begin
                        r_deb[c]   <= r_sync2[c];
                        r_cnt[c]   <= '0;
                        r_event[c] <= r_sync2[c] & r_armed[c];
                    end else begin
                        r_cnt[c] <= r_cnt[c] + 1'b1;
                    end
                end else begin
                    r_cnt[c] <= '0;
                end
            end
        end
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LOCK_W-1:0]   r_lock;
    logic [LOCK_W-1:0]   w_lock_nxt;
    logic                r_nickel;
    logic                r_dime;
    logic                r_reject;
    logic                w_nickel_nxt;
    logic                w_dime_nxt;
    logic                w_reject_nxt;
    logic [TOTAL_W-1:0]  r_total;
    logic [TOTAL_W-1:0]  w_total_nxt;
    logic [SUM_W-1:0]    w_sum;
    logic [3:0]          w_credit;
    logic                w_any;
    logic                w_one;

    assign w_any = |r_event;
    assign w_one = ^r_event;

    // NOTE: every combinational output gets a default first, so no path through the
    // case statement leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_lock_nxt   = r_lock;
        w_nickel_nxt = 1'b0;
        w_dime_nxt   = 1'b0;
        w_reject_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_one && bus.accept_en) begin
                        w_state_nxt  = S_PULSE;
                        w_nickel_nxt = r_event[0];
                        w_dime_nxt   = r_event[1];
                    end else begin
                        w_state_nxt  = S_LOCKOUT;
                        w_lock_nxt   = LOCK_LOAD;
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            S_PULSE: begin
                w_state_nxt  = S_LOCKOUT;
                w_lock_nxt   = LOCK_LOAD;
                w_reject_nxt = w_any;
            end
            S_LOCKOUT: begin
                w_reject_nxt = w_any;
                w_lock_nxt   = r_lock - 1'b1;
                if (r_lock == LOCK_W'(1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_credit    = w_nickel_nxt ? 4'd5 : (w_dime_nxt ? 4'd10 : 4'd0);
        w_sum       = {1'b0, r_total} + SUM_W'(w_credit);
        w_total_nxt = w_sum[TOTAL_W] ? '1 : w_sum[TOTAL_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_lock   <= '0;
            r_nickel <= 1'b0;
            r_dime   <= 1'b0;
            r_reject <= 1'b0;
            r_total  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lock   <= w_lock_nxt;
            r_nickel <= w_nickel_nxt;
            r_dime   <= w_dime_nxt;
            r_reject <= w_reject_nxt;
            r_total  <= w_total_nxt;
        end
    end

    assign bus.nickel_in   = r_nickel;
    assign bus.dime_in     = r_dime;
    assign bus.coin_reject = r_reject;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.cents_total = r_total;
endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the item vending FSMs.
- Converts raw, asynchronous, bouncy coin-sensor lines into clean, single-cycle `nickel_in` / `dime_in` pulses. The per-item FSMs consume these pulses directly.
- Enforces one coin per acceptance window and rejects coins the downstream cannot take.
- Keeps a running cents-accepted total for the service display.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before a sensor level change is believed (legal range 2..15).
- LOCKOUT_CYCLES, 8: cycles after any accepted or rejected coin during which new coin events are rejected (legal range 1..255).
- TOTAL_W, 8: width of the cents-accepted total.

Ports:
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- coin_nickel_raw, input, 1: raw nickel sensor, asynchronous, may bounce.
- coin_dime_raw, input, 1: raw dime sensor, asynchronous, may bounce.
- accept_en, input, 1: downstream ready to take a coin. Sampled in the detection cycle.
- nickel_in, output, 1: one-cycle pulse per accepted nickel.
- dime_in, output, 1: one-cycle pulse per accepted dime.
- coin_reject, output, 1: one-cycle pulse, drives the return-chute gate.
- busy, output, 1: high while the state is PULSE or LOCKOUT.
- cents_total, output, TOTAL_W: cents accepted since reset, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0, FSM to IDLE.
  - Synchronizers, debounced levels, debounce counters and the lockout counter all clear to 0.
  - Release is synchronous to clock. The first edge after reset=1 is treated as cycle 0.
- Synchronization: each raw line passes through a 2-flop synchronizer. Nothing downstream may use a raw line.
- Debounce, per channel:
  - Counter increments each cycle that the synchronized level differs from the debounced level.
  - Counter clears to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles on the next edge and the counter clears.
- Event: a rising edge of a debounced level, registered, gives a 1-cycle event per channel. Falling edges produce nothing.
- Latency: raw high sampled at edge k, held stable, gives the event at edge k+DEBOUNCE_CYCLES+1 and the output pulse in the cycle after edge k+DEBOUNCE_CYCLES+2. Exact, no slack.
- FSM states: IDLE, PULSE, LOCKOUT.
- IDLE transitions:
  - nickel event only, accept_en=1: next cycle nickel_in=1, go to PULSE.
  - dime event only, accept_en=1: next cycle dime_in=1, go to PULSE.
  - Any single event with accept_en=0: next cycle coin_reject=1, go to LOCKOUT.
  - Both events in the same cycle: next cycle coin_reject=1 (one pulse only), go to LOCKOUT, no credit.
- PULSE: lasts exactly 1 cycle, then LOCKOUT. The lockout counter loads LOCKOUT_CYCLES.
- LOCKOUT:
  - Counter decrements each cycle; go to IDLE when it reaches 0.
  - Any event in LOCKOUT gives a coin_reject pulse next cycle. The counter does not restart.
- Reject path: IDLE to LOCKOUT via reject also loads LOCKOUT_CYCLES.
- Output exclusivity: nickel_in, dime_in and coin_reject are mutually exclusive and never high for 2 consecutive cycles from the same event.
- cents_total:
  - Adds 5 on a nickel_in cycle, 10 on a dime_in cycle, updated on the same edge that raises the pulse.
  - Saturates at 2^TOTAL_W-1 and never wraps.
  - Rejects add 0.
- Reset mid-operation: an in-flight pulse is dropped immediately. The total clears. Sensor levels high through reset release are absorbed (debounced level becomes 1 with no event), so no phantom coin is generated.
- busy=1 in PULSE and LOCKOUT, 0 in IDLE.

Test Plan:
- Reset release, sensors low, then clean nickel held 10 cycles with accept_en=1 (defaults):
  - nickel_in is a single pulse exactly 6 edges after the first high sample.
  - cents_total=5.
  - busy high for 1+8 cycles.
- Dime line bouncing 1,0,1,0 at single-cycle intervals, then stable high 6 cycles:
  - Exactly one dime_in pulse.
  - cents_total=10.
  - No pulse generated by the bounce.
- Nickel and dime raised on the same edge, both stable:
  - One coin_reject pulse.
  - No nickel_in or dime_in.
  - cents_total unchanged.
- accept_en=0 at detection of a nickel:
  - coin_reject pulse.
  - Second coin 3 cycles later (inside LOCKOUT) also gives coin_reject.
  - A coin arriving after LOCKOUT with accept_en=1 is accepted.
- 26 dimes accepted back-to-back with TOTAL_W=8:
  - cents_total stops at 255.
  - Every dime_in still pulses.
- reset driven low while the dime sensor is high and in the PULSE state:
  - All outputs go to 0 asynchronously.
  - After release with the sensor still high, no dime_in is produced.
